// File: rtl/uart_cmd_rcv.sv
// rtl/uart_cmd_rcv.sv - assembles two UART bytes (high then low) into a 16-bit command
// with an inter-byte timeout that discards partial commands.
module uart_cmd_rcv #(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int CNT_W       = 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx_rdy,
    input  logic [7:0]  i_rx_data,
    output logic        o_clr_rx_rdy,
    output logic [15:0] o_cmd,
    output logic        o_cmd_rdy,
    input  logic        i_clr_cmd_rdy,
    output logic        o_frm_err,
    output logic        o_cmd_ovr
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOW  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TMO_TERM = CNT_W'(TIMEOUT_CYC - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_hi_byte;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic [15:0]      r_cmd;
    logic             r_cmd_rdy;
    logic             r_frm_err;
    logic             r_cmd_ovr;
    logic             w_ack;
    logic             w_hi_cap;
    logic             w_lo_cap;
    logic             w_tmo;

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_hi_cap    = 1'b0;
        w_lo_cap    = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_rdy) begin
                    w_ack       = 1'b1;
                    w_hi_cap    = 1'b1;
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                // A byte arriving on the terminal count still completes the command.
                if (i_rx_rdy) begin
                    w_ack       = 1'b1;
                    w_lo_cap    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo_cnt == TMO_TERM) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_hi_byte <= 8'h00;
            r_tmo_cnt <= '0;
            r_cmd     <= 16'h0000;
            r_cmd_rdy <= 1'b0;
            r_frm_err <= 1'b0;
            r_cmd_ovr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_frm_err <= w_tmo;
            r_cmd_ovr <= w_lo_cap & r_cmd_rdy & ~i_clr_cmd_rdy;
            if (w_hi_cap) begin
                r_hi_byte <= i_rx_data;
                r_tmo_cnt <= '0;
            end else if (r_state == ST_LOW && !i_rx_rdy) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo) begin
                r_hi_byte <= 8'h00;
            end
            if (w_lo_cap) begin
                r_cmd <= {r_hi_byte, i_rx_data};
            end
            // Set wins over a simultaneous consumer clear.
            if (w_lo_cap) begin
                r_cmd_rdy <= 1'b1;
            end else if (i_clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign o_clr_rx_rdy = w_ack & i_rst_n;
    assign o_cmd        = r_cmd;
    assign o_cmd_rdy    = r_cmd_rdy;
    assign o_frm_err    = r_frm_err;
    assign o_cmd_ovr    = r_cmd_ovr;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// tb/tb_uart_cmd_rcv.sv - self-checking bench for uart_cmd_rcv against a behavioural model
module tb_uart_cmd_rcv;

    localparam int TMO = 100;

    logic        clk;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_cmd_rdy;
    logic        o_clr_rx_rdy;
    logic [15:0] o_cmd;
    logic        o_cmd_rdy;
    logic        o_frm_err;
    logic        o_cmd_ovr;

    int n_cmp;
    int n_err;

    // Behavioural model: are we holding a high byte, which one, and how long since.
    bit         m_have_hi;
    logic [7:0] m_hi;
    int         m_wait;
    logic [15:0] m_cmd;
    bit         m_cmd_rdy;
    bit         m_frm;
    bit         m_ovr;

    uart_cmd_rcv #(.TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_rdy      (rx_rdy),
        .i_rx_data     (rx_data),
        .o_clr_rx_rdy  (o_clr_rx_rdy),
        .o_cmd         (o_cmd),
        .o_cmd_rdy     (o_cmd_rdy),
        .i_clr_cmd_rdy (clr_cmd_rdy),
        .o_frm_err     (o_frm_err),
        .o_cmd_ovr     (o_cmd_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_have_hi = 0;
        m_hi      = 8'h00;
        m_wait    = 0;
        m_cmd     = 16'h0000;
        m_cmd_rdy = 0;
        m_frm     = 0;
        m_ovr     = 0;
    endtask

    // One clock cycle: drive inputs, check the Mealy ack, advance model, check registers.
    task automatic cycle(input logic rdy, input logic [7:0] d, input logic clr);
        bit done;
        @(negedge clk);
        rx_rdy      = rdy;
        rx_data     = rdy ? d : 8'($urandom);
        clr_cmd_rdy = clr;
        #1;
        chk("clr_rx_rdy", {31'd0, o_clr_rx_rdy}, {31'd0, rdy});
        done  = 0;
        m_frm = 0;
        m_ovr = 0;
        if (rdy) begin
            if (!m_have_hi) begin
                m_have_hi = 1;
                m_hi      = rx_data;
                m_wait    = 0;
            end else begin
                m_ovr     = m_cmd_rdy && !clr;
                m_cmd     = {m_hi, rx_data};
                m_have_hi = 0;
                done      = 1;
            end
        end else if (m_have_hi) begin
            m_wait++;
            if (m_wait == TMO) begin
                m_frm     = 1;
                m_have_hi = 0;
            end
        end
        if (done)     m_cmd_rdy = 1;
        else if (clr) m_cmd_rdy = 0;
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        chk("cmd",     {16'd0, o_cmd},     {16'd0, m_cmd});
        chk("cmd_rdy", {31'd0, o_cmd_rdy}, {31'd0, m_cmd_rdy});
        chk("frm_err", {31'd0, o_frm_err}, {31'd0, m_frm});
        chk("cmd_ovr", {31'd0, o_cmd_ovr}, {31'd0, m_ovr});
    endtask

    task automatic idle(input int n, input int clr_pct);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, ($urandom_range(99) < clr_pct));
    endtask

    task automatic send(input logic [7:0] b, input int gap, input logic clr);
        idle(gap, 0);
        cycle(1'b1, b, clr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        rx_rdy      = 1'b1;
        clr_cmd_rdy = 1'b0;
        #1;
        chk("rst_clr_rx_rdy", {31'd0, o_clr_rx_rdy}, 32'd0);
        chk("rst_cmd",        {16'd0, o_cmd},        32'd0);
        chk("rst_cmd_rdy",    {31'd0, o_cmd_rdy},    32'd0);
        chk("rst_frm_ovr",    {30'd0, o_frm_err, o_cmd_ovr}, 32'd0);
        @(negedge clk);
        rx_rdy = 1'b0;
        rst_n  = 1'b1;
        model_clear();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        rx_rdy = 1'b0;
        rx_data = 8'h00;
        clr_cmd_rdy = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        do_reset();

        // 1: basic command, bytes 50 cycles apart
        send(8'hA5, 2, 1'b0);
        send(8'h3C, 49, 1'b0);
        chk("t1_cmd",     {16'd0, o_cmd},     32'h0000A53C);
        chk("t1_cmd_rdy", {31'd0, o_cmd_rdy}, 32'd1);
        chk("t1_frm_err", {31'd0, o_frm_err}, 32'd0);

        // 2: overrun while cmd_rdy held, then consumer clear
        send(8'h12, 3, 1'b0);
        send(8'h34, 1, 1'b0);
        chk("t2_cmd", {16'd0, o_cmd},     32'h00001234);
        chk("t2_ovr", {31'd0, o_cmd_ovr}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t2_ovr_pulse", {31'd0, o_cmd_ovr}, 32'd0);
        chk("t2_clr",       {31'd0, o_cmd_rdy}, 32'd0);

        // 3: timeout exactly TMO cycles after capture, then resync
        send(8'hFF, 2, 1'b0);
        idle(TMO - 1, 0);
        chk("t3_no_frm_early", {31'd0, o_frm_err}, 32'd0);
        idle(1, 0);
        chk("t3_frm",     {31'd0, o_frm_err}, 32'd1);
        chk("t3_cmd_keep", {16'd0, o_cmd},    32'h00001234);
        send(8'h01, 2, 1'b0);
        send(8'h02, 2, 1'b0);
        chk("t3_resync", {16'd0, o_cmd}, 32'h00000102);

        // 4: low byte on the terminal cycle wins over the timeout
        cycle(1'b0, 8'h00, 1'b1);
        send(8'hC1, 1, 1'b0);
        send(8'hD2, TMO - 1, 1'b0);
        chk("t4_cmd", {16'd0, o_cmd},     32'h0000C1D2);
        chk("t4_rdy", {31'd0, o_cmd_rdy}, 32'd1);
        chk("t4_frm", {31'd0, o_frm_err}, 32'd0);
        idle(2, 0);

        // 5: clear coincident with capture, cmd_rdy already set
        send(8'h5A, 1, 1'b0);
        send(8'h6B, 1, 1'b1);
        chk("t5_rdy", {31'd0, o_cmd_rdy}, 32'd1);
        chk("t5_ovr", {31'd0, o_cmd_ovr}, 32'd0);
        chk("t5_cmd", {16'd0, o_cmd},     32'h00005A6B);

        // 6: reset while waiting for the low byte
        send(8'h77, 1, 1'b0);
        idle(3, 0);
        do_reset();
        send(8'h11, 1, 1'b0);
        send(8'h22, 1, 1'b0);
        chk("t6_cmd", {16'd0, o_cmd}, 32'h00001122);

        // Randomised traffic: mostly short gaps, occasional timeout-length gaps
        for (int k = 0; k < 400; k++) begin
            int gap;
            int sel;
            sel = $urandom_range(99);
            if (sel < 6)       gap = TMO - 2 + $urandom_range(3);
            else if (sel < 20) gap = $urandom_range(40);
            else               gap = 1 + $urandom_range(3);
            idle(gap, 20);
            cycle(1'b1, 8'($urandom), ($urandom_range(99) < 25));
            if ($urandom_range(199) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
